adc128s: RTL and testbench
==========================

// Module: adc128s
// PURPOSE
// - Behavioural/synthesizable model of an 8-channel, 12-bit SPI A2D converter (ADC128S-style) for the Segway bench.
// - Serves left/right load-cell and battery readings to the Segway A2D interface over a 4-wire SPI link.
// - Channel selection is pipelined: each frame returns the channel commanded in the previous frame.
// PARAMETERS
// - SYNC_STAGES   2        flops synchronizing SS_n/SCLK/MOSI into clk domain
// - CH_LFT        3'd0     channel returning lft_cell_set
// - CH_RGHT       3'd4     channel returning rght_cell_set
// - CH_BATT       3'd5     channel returning batt_set
// PORTS
// - clk            in   1   system clock; sole clock of the block
// - rst_n          in   1   reset, asynchronous, active-low
// - SS_n           in   1   SPI slave select, active low; frame = one low period
// - SCLK           in   1   SPI clock from master, mode 0 (idle low)
// - MOSI           in   1   command bits from master, MSB first
// - MISO           out  1   result bits to master, MSB first
// - lft_cell_set   in   12  value reported on CH_LFT
// - rght_cell_set  in   12  value reported on CH_RGHT
// - batt_set       in   12  value reported on CH_BATT
// BEHAVIOUR
// - Reset (async, rst_n low): tx_shft=16'h0000, rx_shft=16'h0000, bit_cnt=0, chnl=CH_LFT, MISO=0, sync flops: SS_n=1, SCLK=0.
// - SS_n, SCLK, MOSI pass through SYNC_STAGES flops; edges detected on synchronized copies (1 extra flop).
// - Master SCLK half-period must be >= 4 clk; response latency to any SPI edge <= SYNC_STAGES+1 clk.
// - SS_n fall: tx_shft <= {4'h0, sel(chnl)}; bit_cnt <= 0; set inputs sampled here only (mid-frame changes ignored).
// - sel(chnl): CH_LFT->lft_cell_set, CH_RGHT->rght_cell_set, CH_BATT->batt_set, any other channel->12'h000.
// - SCLK rise (SS_n low): rx_shft <= {rx_shft[14:0], MOSI_sync}; bit_cnt++ (saturates at 16).
// - SCLK fall (SS_n low, bit_cnt>0): tx_shft <= {tx_shft[14:0],1'b0}.
// - MISO = tx_shft[15] at all times (0 while idle after a full frame).
// - SS_n rise: if bit_cnt==16, chnl <= rx_shft[13:11]; else frame aborted, chnl unchanged.
// - Command word format: {2'b00, chnl[2:0], 11'h000}; bits [15:14],[10:0] ignored.
// - Extra SCLK pulses beyond 16 in a frame: rx still shifts, bit_cnt stays 16, tx shifts zeros.
// - SCLK edges while SS_n high: ignored entirely.
// - SS_n fall and SCLK rise in same synchronized cycle: load takes priority, rise counted next edge only.
// - Reset mid-frame: frame discarded, chnl returns to CH_LFT.
// - First frame after reset returns lft_cell_set (chnl=CH_LFT by default).
// STRUCTURE
// - Package adc128s_pkg: CH_LFT/CH_RGHT/CH_BATT constants, FRAME_BITS=16, RES_BITS=12.
// - One sub-module: adc128s_spi_slv (synchronizers, edge detect, 16-bit rx/tx shifters, bit_cnt);
//   top adc128s holds chnl register and channel mux.
// TESTING
// - Reset then frame cmd 16'h0000 with lft=12'h001 -> MISO stream 16'h0001; chnl stays 0.
// - Frame cmd 16'h2000 (ch4) then frame cmd 16'h2800 (ch5), rght=12'h005, batt=12'h015
//   -> second frame returns 16'h0005, third frame returns 16'h0015.
// - Round-robin ch0/ch4/ch5 with lft=12'h018, rght=12'h0FF, batt=12'h123 for 10 conversions
//   -> every returned word matches its set value with upper nibble 4'h0.
// - Abort: raise SS_n after 8 SCLKs of cmd ch5 -> chnl unchanged; next frame returns previous channel's value.
// - Change batt_set 12'h123->12'hABC mid-frame -> current frame still 16'h0123, next ch5 frame 16'h0ABC.
// - Assert rst_n low mid-frame -> MISO=0 immediately; next frame returns lft_cell_set.

Source files
------------

// File: rtl/adc128s_pkg.sv
// Shared constants for the ADC128S-style SPI A2D model: channel map and frame geometry.
package adc128s_pkg;

  localparam logic [2:0] CH_LFT  = 3'd0;
  localparam logic [2:0] CH_RGHT = 3'd4;
  localparam logic [2:0] CH_BATT = 3'd5;

  localparam int FRAME_BITS = 16;
  localparam int RES_BITS   = 12;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  // Position of the channel field inside the received command word
  localparam int CHNL_LSB = 11;

endpackage

// File: rtl/adc128s_spi_slv.sv
// SPI mode-0 slave datapath: input synchronizers, edge detection, 16-bit rx/tx shifters
// and bit counter. Reports a completed frame and the channel field it carried.
module adc128s_spi_slv
  import adc128s_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ss_n,
  input  logic                sclk,
  input  logic                mosi,
  input  logic [RES_BITS-1:0] ld_val,
  output logic                miso,
  output logic                frame_done,
  output logic [2:0]          cmd_chnl
);

  // Packed as {ss_n, sclk, mosi}; idle line state is SS_n high, SCLK low
  localparam logic [2:0]       SYNC_RST = 3'b100;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  logic [SYNC_STAGES-1:0][2:0] sync_reg;
  logic                        ss_prev_reg;
  logic                        sclk_prev_reg;
  logic [FRAME_BITS-1:0]       tx_shft_reg;
  logic [FRAME_BITS-1:0]       rx_shft_reg;
  logic [CNT_W-1:0]            bit_cnt_reg;

  logic ss_s, sclk_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {SYNC_STAGES{SYNC_RST}};
    end else begin
      sync_reg[0] <= {ss_n, sclk, mosi};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign ss_s   = sync_reg[SYNC_STAGES-1][2];
  assign sclk_s = sync_reg[SYNC_STAGES-1][1];
  assign mosi_s = sync_reg[SYNC_STAGES-1][0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_prev_reg   <= 1'b1;
      sclk_prev_reg <= 1'b0;
    end else begin
      ss_prev_reg   <= ss_s;
      sclk_prev_reg <= sclk_s;
    end
  end

  // SCLK activity only counts while the frame is open
  assign ss_fall   =  ss_prev_reg & ~ss_s;
  assign ss_rise   = ~ss_prev_reg &  ss_s;
  assign sclk_rise = ~sclk_prev_reg &  sclk_s & ~ss_s;
  assign sclk_fall =  sclk_prev_reg & ~sclk_s & ~ss_s;

  // Frame load wins over a coincident SCLK rise; that rise is simply dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft_reg <= '0;
      rx_shft_reg <= '0;
      bit_cnt_reg <= '0;
    end else if (ss_fall) begin
      tx_shft_reg <= {{(FRAME_BITS-RES_BITS){1'b0}}, ld_val};
      bit_cnt_reg <= '0;
    end else if (sclk_rise) begin
      rx_shft_reg <= {rx_shft_reg[FRAME_BITS-2:0], mosi_s};
      if (bit_cnt_reg != CNT_FULL) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end else if (sclk_fall && (bit_cnt_reg != '0)) begin
      tx_shft_reg <= {tx_shft_reg[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign miso       = tx_shft_reg[FRAME_BITS-1];
  assign frame_done = ss_rise && (bit_cnt_reg == CNT_FULL);
  assign cmd_chnl   = rx_shft_reg[CHNL_LSB+2:CHNL_LSB];

endmodule

// File: rtl/adc128s.sv
// ADC128S-style 8-channel SPI A2D model. Holds the pipelined channel register and the
// result mux; each frame returns the channel commanded by the previous complete frame.
module adc128s
  import adc128s_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                SCLK,
  input  logic                MOSI,
  output logic                MISO,
  input  logic [RES_BITS-1:0] lft_cell_set,
  input  logic [RES_BITS-1:0] rght_cell_set,
  input  logic [RES_BITS-1:0] batt_set
);

  logic [2:0]          chnl_reg;
  logic [RES_BITS-1:0] sel_val;
  logic                frame_done;
  logic [2:0]          cmd_chnl;

  // Unpopulated channels read back as zero
  always_comb begin
    sel_val = '0;
    case (chnl_reg)
      CH_LFT:  sel_val = lft_cell_set;
      CH_RGHT: sel_val = rght_cell_set;
      CH_BATT: sel_val = batt_set;
      default: sel_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chnl_reg <= CH_LFT;
    end else if (frame_done) begin
      chnl_reg <= cmd_chnl;
    end
  end

  adc128s_spi_slv #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_spi_slv (
    .clk       (clk),
    .rst_n     (rst_n),
    .ss_n      (SS_n),
    .sclk      (SCLK),
    .mosi      (MOSI),
    .ld_val    (sel_val),
    .miso      (MISO),
    .frame_done(frame_done),
    .cmd_chnl  (cmd_chnl)
  );

endmodule

// File: tb/tb_adc128s.sv
// Directed bench for adc128s: table of full SPI frames plus hand-written abort,
// mid-frame update, over-length frame and mid-frame reset sequences.
module tb_adc128s;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [11:0] lft_cell_set = '0;
  logic [11:0] rght_cell_set = '0;
  logic [11:0] batt_set = '0;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int HALF = 5;  // SCLK half-period in clk cycles

  adc128s #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .lft_cell_set (lft_cell_set),
    .rght_cell_set(rght_cell_set),
    .batt_set     (batt_set)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    logic [11:0] lft;
    logic [11:0] rght;
    logic [11:0] batt;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s: got %h", name, act);
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic half_wait();
    repeat (HALF) @(negedge clk);
  endtask

  // One SPI frame of nbits clocks; optionally change batt_set before bit chg_bit
  task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int chg_bit,
                           input logic [11:0] chg_val, output logic [31:0] resp);
    logic [15:0] c;
    c = cmd;
    resp = '0;
    @(negedge clk);
    SS_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) batt_set = chg_val;
      MOSI = (i < 16) ? c[15-i] : 1'b0;
      half_wait();
      SCLK = 1'b1;
      resp = {resp[30:0], MISO};
      half_wait();
      SCLK = 1'b0;
    end
    half_wait();
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  logic [15:0] rr_cmd [3];
  logic [15:0] rr_exp [3];
  logic [31:0] resp;

  initial begin
    vecs[0] = '{16'h0000, 12'h001, 12'h005, 12'h015, 16'h0001};
    vecs[1] = '{16'h2000, 12'h001, 12'h005, 12'h015, 16'h0001};
    vecs[2] = '{16'h2800, 12'h001, 12'h005, 12'h015, 16'h0005};
    vecs[3] = '{16'h0000, 12'h001, 12'h005, 12'h015, 16'h0015};
    rr_cmd = '{16'h2000, 16'h2800, 16'h0000};
    rr_exp = '{16'h0018, 16'h00FF, 16'h0123};
    for (int k = 0; k < 10; k++) begin
      vecs[4+k] = '{rr_cmd[k%3], 12'h018, 12'h0FF, 12'h123, rr_exp[k%3]};
    end
    vecs[14] = '{16'h1800, 12'h018, 12'h0FF, 12'h123, 16'h00FF};  // -> ch3
    vecs[15] = '{16'hE7FF, 12'h018, 12'h0FF, 12'h123, 16'h0000};  // ch3 empty; junk bits -> ch4
    vecs[16] = '{16'h2800, 12'h018, 12'h0FF, 12'h123, 16'h00FF};  // -> ch5

    repeat (3) @(negedge clk);
    #1 check("reset_miso", {31'b0, MISO}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_miso", {31'b0, MISO}, 32'h0);

    for (int v = 0; v < 17; v++) begin
      lft_cell_set  = vecs[v].lft;
      rght_cell_set = vecs[v].rght;
      batt_set      = vecs[v].batt;
      spi_frame(vecs[v].cmd, 16, -1, 12'h000, resp);
      check($sformatf("vec%0d cmd=%h", v, vecs[v].cmd), {16'h0, resp[15:0]}, {16'h0, vecs[v].exp});
    end

    // Abort: 8 clocks of a ch4 command, channel must stay ch5
    spi_frame(16'h2000, 8, -1, 12'h000, resp);
    check("abort_partial", {24'h0, resp[7:0]}, 32'h01);
    spi_frame(16'h0000, 16, -1, 12'h000, resp);
    check("abort_next", {16'h0, resp[15:0]}, 32'h0123);

    // batt_set changes mid-frame: sampled value is the one at SS_n fall
    spi_frame(16'h2800, 16, -1, 12'h000, resp);
    check("chg_setup", {16'h0, resp[15:0]}, 32'h0018);
    spi_frame(16'h2800, 16, 4, 12'hABC, resp);
    check("chg_cur", {16'h0, resp[15:0]}, 32'h0123);
    spi_frame(16'h0000, 16, -1, 12'h000, resp);
    check("chg_next", {16'h0, resp[15:0]}, 32'h0ABC);
    check("idle_after_frame", {31'b0, MISO}, 32'h0);

    // 17 clocks: rx keeps shifting so the channel field lands on cmd[12:10] = ch5
    spi_frame(16'h1400, 17, -1, 12'h000, resp);
    check("extra_clk_resp", {15'h0, resp[16:0]}, 32'h0_0030);
    spi_frame(16'h0000, 16, -1, 12'h000, resp);
    check("extra_clk_next", {16'h0, resp[15:0]}, 32'h0ABC);

    // Select ch5 again, then reset part-way through a frame
    spi_frame(16'h2800, 16, -1, 12'h000, resp);
    check("rst_setup", {16'h0, resp[15:0]}, 32'h0018);
    @(negedge clk);
    SS_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      MOSI = 1'b0;
      half_wait();
      SCLK = 1'b1;
      half_wait();
      SCLK = 1'b0;
    end
    half_wait();
    check("rst_pre_miso", {31'b0, MISO}, 32'h1);
    rst_n = 1'b0;
    #1 check("rst_mid_miso", {31'b0, MISO}, 32'h0);
    repeat (2) @(negedge clk);
    SS_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    spi_frame(16'h0000, 16, -1, 12'h000, resp);
    check("rst_next", {16'h0, resp[15:0]}, 32'h0018);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
